// File: rtl/external_io_buffered.sv
// Host IO block: two oversampled SPI slaves for job/device configuration and a
// result FIFO that is drained over SPI1 while the shapool runs.
module external_io_buffered #(
  parameter int JOB_CONFIG_WIDTH    = 64,
  parameter int DEVICE_CONFIG_WIDTH = 8,
  parameter int RESULT_WIDTH        = 32,
  parameter int RESULT_DEPTH        = 4,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              sck0,
  input  logic                              sdi0,
  input  logic                              cs0_n,
  input  logic                              sck1,
  input  logic                              sdi1,
  output logic                              sdo1,
  input  logic                              cs1_n,
  output logic [DEVICE_CONFIG_WIDTH-1:0]    device_config,
  output logic [JOB_CONFIG_WIDTH-1:0]       job_config,
  output logic                              exec,
  input  logic [RESULT_WIDTH-1:0]           shapool_result,
  input  logic                              shapool_success,
  output logic [$clog2(RESULT_DEPTH):0]     result_count,
  output logic                              overflow
);

  localparam int PW = $clog2(RESULT_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(JOB_CONFIG_WIDTH + 2);
  localparam logic [CW-1:0] DEPTH_C  = CW'(RESULT_DEPTH);
  localparam logic [BW-1:0] JOB_BITS = BW'(JOB_CONFIG_WIDTH);
  localparam logic [BW-1:0] JOB_SAT  = BW'(JOB_CONFIG_WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [5:0]                      pins;
  logic [SYNC_STAGES-1:0][5:0]     sync_reg;
  logic [5:0]                      synced;
  logic [3:0]                      prev_reg;
  logic                            sck0_rise, cs0_rise, sck1_rise, cs1_fall;
  logic                            sdi0_s, cs0_s, sdi1_s, cs1_s;

  logic [1:0]                      state_reg, state_next;
  logic [BW-1:0]                   bit_cnt_reg;
  logic [JOB_CONFIG_WIDTH-1:0]     job_config_reg;
  logic [DEVICE_CONFIG_WIDTH-1:0]  device_config_reg;
  logic [RESULT_WIDTH:0]           rd_sr_reg;
  logic [RESULT_WIDTH-1:0]         fifo_mem [RESULT_DEPTH];
  logic [PW-1:0]                   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]                   count_reg, count_next;
  logic                            overflow_reg;
  logic                            active, push, pop, drop;

  assign pins   = {cs1_n, sdi1, sck1, cs0_n, sdi0, sck0};
  assign synced = sync_reg[SYNC_STAGES-1];

  // Edges compare the synchroniser output against one further delayed copy.
  assign sck0_rise = synced[0] & ~prev_reg[0];
  assign cs0_rise  = synced[2] & ~prev_reg[1];
  assign sck1_rise = synced[3] & ~prev_reg[2];
  assign cs1_fall  = ~synced[5] & prev_reg[3];
  assign sdi0_s    = synced[1];
  assign cs0_s     = synced[2];
  assign sdi1_s    = synced[4];
  assign cs1_s     = synced[5];

  assign active = (state_reg == EXEC) || (state_reg == DONE);
  // Push eligibility uses the pre-pop occupancy, so a full FIFO never bypasses.
  assign push   = active && shapool_success && (count_reg < DEPTH_C);
  assign drop   = active && shapool_success && !(count_reg < DEPTH_C);
  assign pop    = active && cs1_fall && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (cs0_rise && (bit_cnt_reg == JOB_BITS)) state_next = EXEC;
      EXEC: if (push && (count_next == DEPTH_C)) state_next = DONE;
      DONE: if (pop && (count_next < DEPTH_C)) state_next = EXEC;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= shapool_result;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_reg          <= '0;
      prev_reg          <= '0;
      state_reg         <= IDLE;
      bit_cnt_reg       <= '0;
      job_config_reg    <= '0;
      device_config_reg <= '0;
      rd_sr_reg         <= '0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
      overflow_reg      <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], pins};
      prev_reg     <= {synced[5], synced[3], synced[2], synced[0]};
      state_reg    <= state_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_reg | drop;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);

      case (state_reg)
        IDLE: begin
          if (cs0_rise) begin
            bit_cnt_reg <= '0;
          end else if (sck0_rise && !cs0_s) begin
            job_config_reg <= {job_config_reg[JOB_CONFIG_WIDTH-2:0], sdi0_s};
            if (bit_cnt_reg != JOB_SAT) bit_cnt_reg <= bit_cnt_reg + BW'(1);
          end
          if (sck1_rise && !cs1_s)
            device_config_reg <= {device_config_reg[DEVICE_CONFIG_WIDTH-2:0], sdi1_s};
        end
        EXEC, DONE: begin
          // Valid flag leads the frame; an empty FIFO reads back all zeros.
          if (cs1_fall)
            rd_sr_reg <= pop ? {1'b1, fifo_mem[rd_ptr_reg]} : '0;
          else if (sck1_rise && !cs1_s)
            rd_sr_reg <= {rd_sr_reg[RESULT_WIDTH-1:0], sdi1_s};
        end
        default: ;
      endcase
    end
  end

  assign job_config    = job_config_reg;
  assign device_config = device_config_reg;
  assign exec          = (state_reg == EXEC);
  assign result_count  = count_reg;
  assign overflow      = overflow_reg;
  assign sdo1          = (state_reg == IDLE) ? device_config_reg[DEVICE_CONFIG_WIDTH-1]
                                             : rd_sr_reg[RESULT_WIDTH];

endmodule

// File: doc/external_io_buffered.md
Name: external_io_buffered

Overview:
Next-generation host IO block for the shapool top level. Two SPI slave ports are oversampled in the clk domain.
- SPI0 loads the job configuration.
- SPI1 loads the device configuration in IDLE and reads results during and after execution.
- Winning results are captured into a RESULT_DEPTH-entry FIFO, so multiple successes per job are kept rather than only the first.
- Mining pauses automatically when the FIFO is full.

Parameters:
JOB_CONFIG_WIDTH, 64, job configuration bits shifted in on SPI0 (>=2)
DEVICE_CONFIG_WIDTH, 8, device configuration bits shifted in on SPI1 (>=2)
RESULT_WIDTH, 32, width of shapool_result and of each FIFO entry (>=2)
RESULT_DEPTH, 4, FIFO entries; power of two, >=2
SYNC_STAGES, 2, synchroniser flops on each SPI input (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
sck0  in  1  SPI0 clock, async
sdi0  in  1  SPI0 data in
cs0_n  in  1  SPI0 chip select, active low
sck1  in  1  SPI1 clock, async
sdi1  in  1  SPI1 data in
sdo1  out  1  SPI1 data out
cs1_n  in  1  SPI1 chip select, active low
device_config  out  DEVICE_CONFIG_WIDTH  stored device config
job_config  out  JOB_CONFIG_WIDTH  stored job config
exec  out  1  high only in EXEC; shapool run enable
shapool_result  in  RESULT_WIDTH  result word, valid with shapool_success
shapool_success  in  1  one-cycle success strobe
result_count  out  $clog2(RESULT_DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a result was dropped

Behaviour:
- Reset is reset_n: synchronous, active-low, on clk. All outputs, FIFO pointers, bit counter, shift registers and synchronisers clear to 0; state=IDLE. Reset mid-frame or mid-exec aborts all activity. The only way back to IDLE is reset.
- Each SPI input passes through SYNC_STAGES flops. An edge is a change between the last two synchronised samples.
- SPI is mode 0, MSB first; data is sampled on sck rise. Requires f_clk >= 4*f_sck.
- States: IDLE=0, EXEC=1, DONE=2; the unused encoding goes to IDLE.
- IDLE, SPI0:
  - Each sck0 rise with cs0_n low shifts job_config left, inserting sdi0 at the LSB.
  - A bit counter increments and saturates at JOB_CONFIG_WIDTH+1.
  - On cs0_n rise: if count == JOB_CONFIG_WIDTH, go to EXEC. Otherwise stay in IDLE; job_config keeps the shifted bits.
  - The counter clears on every cs0_n rise.
- IDLE, SPI1:
  - Each sck1 rise with cs1_n low shifts device_config left, inserting sdi1.
  - sdo1 = device_config MSB, giving readback of the old value while shifting.
- EXEC:
  - exec=1.
  - shapool_success pushes shapool_result if result_count < RESULT_DEPTH before any same-cycle pop. Otherwise the result is dropped and overflow is set.
  - A push that makes the FIFO full moves to DONE in the next cycle.
  - SPI0 is ignored. device_config is frozen.
- DONE:
  - exec=0.
  - Pushes still follow the EXEC rules, so an in-flight success on the transition cycle is accepted if there is space.
  - Returns to EXEC when result_count < RESULT_DEPTH after a pop.
- Readout (EXEC and DONE) uses a RESULT_WIDTH+1 shift register rd_sr:
  - On cs1_n fall, load rd_sr = {1, FIFO head} and pop if the FIFO is non-empty; otherwise load all zeros (valid bit 0).
  - Each sck1 rise with cs1_n low shifts rd_sr left, inserting sdi1.
  - sdo1 = rd_sr MSB. The valid bit appears first, then the result MSB first.
  - A frame aborted early still consumes the popped entry.
- Simultaneous push and pop: both take effect and result_count is unchanged. When full, the push is still rejected (no bypass).
- FIFO pointers are log2(RESULT_DEPTH) bits and wrap modulo RESULT_DEPTH. result_count is updated in the same cycle as the push or pop.
- overflow clears only on reset.

Test Plan:
- Reset then load: shift 64 bits 0x0123456789ABCDEF on SPI0, release cs0_n -> job_config=0x0123456789ABCDEF; exec=1 within SYNC_STAGES+2 clk after the cs0_n rise.
- Short frame: 63 bits then cs0_n rise -> state stays IDLE, exec=0. A following 64-bit frame then enters EXEC.
- Device config: shift 0xA5 on SPI1 in IDLE -> device_config=0xA5. First sdo1 bits of a second frame read 1,0,1,0,0,1,0,1.
- Multi-result: successes carrying 0x11, 0x22, 0x33 -> result_count=3. Three 33-bit SPI1 reads return {1,0x11}, {1,0x22}, {1,0x33}. A fourth read returns 33 zeros.
- Full/overflow: 5 successes with RESULT_DEPTH=4 -> exec=0 after the 4th, 5th dropped, overflow=1, count=4. One read -> count=3, exec=1.
- Simultaneous + reset: pop and push in the same clk with count=2 -> count stays 2. Assert reset_n low mid-frame -> all outputs 0, state IDLE.
